// File: rtl/mem_access_ctrl_if.sv
// Bundle of the CPU command/data handshakes and the memory port of mem_access_ctrl.
// The master modport is the controller's view; slave is the CPU datapath plus memory side.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 19,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              done;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  wdata_valid, wdata, mem_read_data,
        output req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, done,
        output mem_read, mem_write, mem_address, mem_write_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output wdata_valid, wdata, mem_read_data,
        input  req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, done,
        input  mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Burst load/store master for the memory port: one memory operation per cycle with an
// auto-incrementing address, load data returned as a tagged stream plus a done pulse.
module mem_access_ctrl #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 19,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_last_q, rsp_last_d;
    logic              beat;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        // The memory registers its read data, so the response flags lag the strobe by one cycle.
        rsp_valid_d = (state_q == READ);
        rsp_last_d  = (state_q == READ) && (cnt_q == '0);
        beat        = dir_q ? ((state_q == WRITE) && bus.wdata_valid) : (state_q == READ);

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    cnt_d   = bus.req_len;
                    dir_d   = bus.req_write;
                    state_d = bus.req_write ? WRITE : READ;
                end
            end
            READ, WRITE: begin
                if (beat) begin
                    addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // Strobes decode straight from the state register so a reset kills them immediately.
    assign bus.req_ready      = (state_q == IDLE);
    assign bus.wdata_ready    = (state_q == WRITE);
    assign bus.mem_read       = (state_q == READ);
    assign bus.mem_write      = (state_q == WRITE) && bus.wdata_valid;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = bus.wdata;
    assign bus.done           = (state_q == DONE);
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_last       = rsp_last_q;
    assign bus.rsp_data       = bus.mem_read_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a memory block, an event monitor and a
// transaction-level reference model predicting every strobe, response and done pulse.
module tb_mem_access_ctrl;
    localparam int DATA_W = 19;
    localparam int ADDR_W = 19;
    localparam int LEN_W  = 4;
    localparam int MEMSZ  = 1 << ADDR_W;
    localparam int AMASK  = MEMSZ - 1;
    localparam int DMASK  = (1 << DATA_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();
    mem_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory block: registered read, word 5 preloaded with 0x1234, others with a fixed pattern.
    function automatic logic [DATA_W-1:0] init_word(input int a);
        if (a == 5) return DATA_W'('h1234);
        return DATA_W'(a * 37 + 421);
    endfunction

    logic [DATA_W-1:0] mem [0:MEMSZ-1];
    bit                written [0:MEMSZ-1];
    logic [DATA_W-1:0] rd_q;
    always @(posedge clk) begin
        if (bus.mem_read)
            rd_q <= written[bus.mem_address] ? mem[bus.mem_address] : init_word(int'(bus.mem_address));
        if (bus.mem_write) begin
            mem[bus.mem_address]     <= bus.mem_write_data;
            written[bus.mem_address] <= 1'b1;
        end
    end
    assign bus.mem_read_data = rd_q;

    // Event kinds: 0 accept, 1 read strobe, 2 write strobe, 3 response beat, 4 done.
    typedef struct packed { int k; int c; int a; int d; } ev_t;
    ev_t obs_q[$];
    ev_t exp_q[$];
    int  both_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_valid && bus.req_ready)
                obs_q.push_back('{0, cyc, int'(bus.req_addr), int'({bus.req_write, bus.req_len})});
            if (bus.mem_read)  obs_q.push_back('{1, cyc, int'(bus.mem_address), 0});
            if (bus.mem_write) obs_q.push_back('{2, cyc, int'(bus.mem_address), int'(bus.mem_write_data)});
            if (bus.rsp_valid) obs_q.push_back('{3, cyc, int'(bus.rsp_last), int'(bus.rsp_data)});
            if (bus.done)      obs_q.push_back('{4, cyc, 0, 0});
            if (bus.mem_read && bus.mem_write) both_cnt++;
        end
    end

    // Reference model.
    logic [DATA_W-1:0] ref_mem [0:MEMSZ-1];
    int gap_tbl [16];
    int sdat [16];

    function automatic void exp_push(input int k, input int c, input int a, input int d);
        ev_t e;
        int  pos;
        e   = '{k, c, a, d};
        pos = exp_q.size();
        while (pos > 0 && (exp_q[pos-1].c > c || (exp_q[pos-1].c == c && exp_q[pos-1].k > k))) pos--;
        exp_q.insert(pos, e);
    endfunction

    function automatic void model_load(input int acc, input int addr, input int len);
        for (int i = 0; i <= len; i++) begin
            int a;
            a = (addr + i) & AMASK;
            exp_push(1, acc + 1 + i, a, 0);
            exp_push(3, acc + 2 + i, (i == len) ? 1 : 0, int'(ref_mem[a]));
        end
        exp_push(4, acc + len + 2, 0, 0);
    endfunction

    function automatic void model_write(input int c, input int a, input int d);
        exp_push(2, c, a, d);
        ref_mem[a] = DATA_W'(d);
    endfunction

    task automatic clear_events();
        obs_q.delete();
        exp_q.delete();
        both_cnt = 0;
    endtask

    task automatic wait_ready(output bit ok);
        int w;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        ok = (w < 50);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_ready req_ready=%b after %0d cycles, required 1", bus.req_ready, w);
        end
    endtask

    task automatic issue_load(input int addr, input int len);
        bit ok;
        int a0;
        wait_ready(ok);
        if (!ok) return;
        a0 = cyc;
        bus.req_valid = 1'b1; bus.req_write = 1'b0;
        bus.req_addr = ADDR_W'(addr); bus.req_len = LEN_W'(len);
        exp_push(0, a0, addr, len);
        model_load(a0, addr, len);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (len + 2) @(posedge clk);
        #1;
    endtask

    task automatic issue_store(input int addr, input int len);
        bit ok;
        int a0;
        wait_ready(ok);
        if (!ok) return;
        a0 = cyc;
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = ADDR_W'(addr); bus.req_len = LEN_W'(len);
        exp_push(0, a0, addr, 16 + len);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            for (int g = 0; g < gap_tbl[i]; g++) begin
                bus.wdata_valid = 1'b0; bus.wdata = DATA_W'($urandom);
                @(posedge clk); #1;
            end
            bus.wdata_valid = 1'b1; bus.wdata = DATA_W'(sdat[i]);
            model_write(cyc, (addr + i) & AMASK, sdat[i] & DMASK);
            @(posedge clk); #1;
        end
        bus.wdata_valid = 1'b0;
        exp_push(4, cyc, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.wdata_ready !== 1'b0) begin errors++; $display("FAIL reset_wdata_ready got %b want 0", bus.wdata_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got %b want 0", bus.rsp_last); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b want 0", bus.mem_read); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b want 0", bus.mem_write); end
        checks++; if (bus.mem_address !== '0) begin errors++; $display("FAIL reset_mem_address got %h want 0", bus.mem_address); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_load();
        clear_events();
        issue_load(5, 0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_load events got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_load ev%0d got k%0d c%0d a%h d%h want k%0d c%0d a%h d%h", i,
                         obs_q[i].k, obs_q[i].c, obs_q[i].a, obs_q[i].d, exp_q[i].k, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_store_gaps();
        clear_events();
        sdat[0] = 'h11; sdat[1] = 'h22; sdat[2] = 'h33; sdat[3] = 'h44;
        for (int i = 0; i < 16; i++) gap_tbl[i] = 0;
        gap_tbl[2] = 2;
        issue_store('hE, 3);
        issue_load('hE, 3);
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL store_gaps both_strobes got %0d want 0", both_cnt); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL store_gaps events got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL store_gaps ev%0d got k%0d c%0d a%h d%h want k%0d c%0d a%h d%h", i,
                         obs_q[i].k, obs_q[i].c, obs_q[i].a, obs_q[i].d, exp_q[i].k, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_wrap();
        clear_events();
        issue_load('h7FFFE, 2);
        for (int i = 0; i < 16; i++) begin gap_tbl[i] = 0; sdat[i] = int'($urandom) & DMASK; end
        issue_store('h7FFFF, 1);
        issue_load('h7FFFF, 1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap events got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap ev%0d got k%0d c%0d a%h d%h want k%0d c%0d a%h d%h", i,
                         obs_q[i].k, obs_q[i].c, obs_q[i].a, obs_q[i].d, exp_q[i].k, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_random();
        clear_events();
        for (int n = 0; n < 12; n++) begin
            int addr, len;
            addr = ($urandom_range(0, 3) == 0) ? (AMASK - int'($urandom_range(0, 6))) : (int'($urandom) & 'h3F);
            len  = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    gap_tbl[i] = int'($urandom_range(0, 2));
                    sdat[i]    = int'($urandom) & DMASK;
                end
                issue_store(addr, len);
            end else begin
                issue_load(addr, len);
            end
        end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL random both_strobes got %0d want 0", both_cnt); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random events got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random ev%0d got k%0d c%0d a%h d%h want k%0d c%0d a%h d%h", i,
                         obs_q[i].k, obs_q[i].c, obs_q[i].a, obs_q[i].d, exp_q[i].k, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ca [8];
        int cl [8];
        int cw [8];
        int acc [8];
        int drv [int];
        int tend, k;
        clear_events();
        for (int i = 0; i < 8; i++) begin
            cw[i] = i % 2;
            ca[i] = int'($urandom) & AMASK;
            cl[i] = int'($urandom_range(0, 5));
        end
        // Accepts are predicted purely from command lengths: each command occupies len+3 cycles.
        acc[0] = cyc;
        for (int i = 1; i < 8; i++) acc[i] = acc[i-1] + cl[i-1] + 3;
        tend = acc[7] + cl[7] + 4;
        bus.wdata_valid = 1'b1;
        bus.req_valid   = 1'b1;
        while (cyc < tend) begin
            k = 0;
            while (k < 8 && acc[k] < cyc) k++;
            bus.req_valid = (k < 8);
            if (k < 8 && acc[k] == cyc) begin
                bus.req_write = cw[k][0]; bus.req_addr = ADDR_W'(ca[k]); bus.req_len = LEN_W'(cl[k]);
            end else begin
                bus.req_write = 1'($urandom); bus.req_addr = ADDR_W'($urandom); bus.req_len = LEN_W'($urandom);
            end
            bus.wdata = DATA_W'($urandom);
            drv[cyc]  = int'(bus.wdata);
            @(posedge clk); #1;
        end
        bus.req_valid   = 1'b0;
        bus.wdata_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_push(0, acc[i], ca[i], cw[i] * 16 + cl[i]);
            if (cw[i] == 1) begin
                for (int b = 0; b <= cl[i]; b++) model_write(acc[i] + 1 + b, (ca[i] + b) & AMASK, drv[acc[i] + 1 + b]);
                exp_push(4, acc[i] + cl[i] + 2, 0, 0);
            end else begin
                model_load(acc[i], ca[i], cl[i]);
            end
        end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL back_to_back both_strobes got %0d want 0", both_cnt); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL back_to_back events got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL back_to_back ev%0d got k%0d c%0d a%h d%h want k%0d c%0d a%h d%h", i,
                         obs_q[i].k, obs_q[i].c, obs_q[i].a, obs_q[i].d, exp_q[i].k, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int a0;
        bit ok;
        clear_events();
        wait_ready(ok);
        if (!ok) return;
        a0 = int'($urandom) & 'hFF;
        bus.req_valid = 1'b1; bus.req_write = 1'b0;
        bus.req_addr = ADDR_W'(a0); bus.req_len = LEN_W'(7);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL midrst_pre_mem_read got %b want 1", bus.mem_read); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL midrst_mem_read got %b want 0", bus.mem_read); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.mem_address !== '0) begin errors++; $display("FAIL midrst_mem_address got %h want 0", bus.mem_address); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_events();
        repeat (4) @(posedge clk);
        #1;
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_quiet events got %0d want 0", obs_q.size()); end
        clear_events();
        issue_load(a0 + 3, 0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_reload events got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_reload ev%0d got k%0d c%0d a%h d%h want k%0d c%0d a%h d%h", i,
                         obs_q[i].k, obs_q[i].c, obs_q[i].a, obs_q[i].d, exp_q[i].k, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        for (int i = 0; i < MEMSZ; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_single_load();
        test_store_gaps();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side master for the 19-bit memory port: accepts single-word or burst load/store commands from the CPU datapath over a valid/ready handshake and drives `mem_read`/`mem_write`/address/data toward the memory block. It issues one memory operation per cycle with an auto-incrementing address, absorbs the memory's 1-cycle registered read latency, and returns load data as a tagged stream with a completion pulse.

## Interface
- `DATA_W`, 19, data word width
- `ADDR_W`, 19, address width
- `LEN_W`, 4, burst length field width (beats = len+1, max 16)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  command valid
- `req_ready`  out  1  command accepted when `req_valid && req_ready`
- `req_write`  in  1  1 = store burst, 0 = load burst
- `req_addr`  in  ADDR_W  start word address
- `req_len`  in  LEN_W  beats minus 1
- `wdata_valid`  in  1  store data beat valid
- `wdata_ready`  out  1  store data beat accepted when both high
- `wdata`  in  DATA_W  store data beat
- `rsp_valid`  out  1  load data beat valid (no backpressure)
- `rsp_data`  out  DATA_W  load data beat
- `rsp_last`  out  1  final load beat
- `done`  out  1  one-cycle completion pulse
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `mem_address`  out  ADDR_W  memory address
- `mem_write_data`  out  DATA_W  memory write data
- `mem_read_data`  in  DATA_W  memory read data, valid the cycle after `mem_read` is sampled

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: `addr_q` (ADDR_W), `cnt_q` (LEN_W, beats remaining minus 1), `dir_q`.
- IDLE: `req_ready`=1. On accept: `addr_q`←`req_addr`, `cnt_q`←`req_len`, go to READ (`req_write`=0) or WRITE (`req_write`=1).
- READ: `mem_read`=1, `mem_address`=`addr_q` every cycle; `addr_q`++; if `cnt_q`==0 go to DONE, else `cnt_q`--.
- WRITE: `wdata_ready`=1; `mem_write`=`wdata_valid`, `mem_write_data`=`wdata`, `mem_address`=`addr_q`. Beat advances only when `wdata_valid`=1 (`addr_q`++, `cnt_q`--); last beat (`cnt_q`==0) goes to DONE. No beat → stay, no write.
- DONE: `done`=1 for exactly one cycle, then IDLE. `req_ready`=0.
- Load return: `rsp_valid` is a registered copy of `mem_read`; `rsp_data`=`mem_read_data` (pass-through); `rsp_last` registered high for the beat issued with `cnt_q`==0.
- Address arithmetic: ADDR_W-bit increment, wraps 0x7FFFF→0x00000; no error flag.
- `mem_read` and `mem_write` are never high in the same cycle.
- `req_valid` outside IDLE is ignored (not accepted, not queued).

## Timing
- Reset (async, immediate): state=IDLE, `addr_q`=0, `cnt_q`=0; `req_ready`=1, `wdata_ready`=0, `rsp_valid`=0, `rsp_last`=0, `done`=0, `mem_read`=0, `mem_write`=0, `mem_address`=0. Flops held while `rst_n`=0, so no command is accepted during reset.
- Reset mid-burst: burst abandoned, no further memory strobes, no `done`; any read already sampled by memory returns data that is not flagged (`rsp_valid`=0).
- Load of L+1 beats accepted in cycle A: `mem_read` in A+1…A+L+1; `rsp_valid` in A+2…A+L+2; `rsp_last` and `done` both in A+L+2; `req_ready` again in A+L+3.
- Store: one write per cycle with `wdata_valid`; `done` the cycle after the last beat; minimum occupancy L+3 cycles including accept.
- Back-to-back commands: minimum spacing of accepts is L+3 cycles.

## Test plan
- Reset mid-load (len 7, after 3 beats) → `mem_read`, `rsp_valid`, `done` drop to 0 asynchronously, `req_ready`=1; next single load returns correct data.
- Memory word 5 = 0x1234; load addr 5 len 0 → one `mem_read` at 5, next cycle `rsp_valid`=1, `rsp_data`=0x1234, `rsp_last`=1, `done`=1.
- Store addr 0xE len 3, data 0x11,0x22,0x33,0x44 with `wdata_valid` low for 2 cycles between beats 1 and 2 → writes to 0xE,0xF,0x10,0x11 only on valid cycles; `done` one cycle after 4th write; load-back of the same range returns 0x11,0x22,0x33,0x44, `rsp_last` on the 4th.
- Load addr 0x7FFFE len 2 → `mem_address` 0x7FFFE, 0x7FFFF, 0x00000.
- `req_valid` held high continuously with alternating commands → each accepted only in IDLE, spacing exactly L+3 cycles for loads, `mem_read`/`mem_write` never simultaneous.
